// File: rtl/din_debounce_sync.sv
// din_debounce_sync
// Turns a raw, bouncy asynchronous input into a clean clock-synchronous level.
// The input passes through a reset-to-zero synchronizer chain. A four-state FSM
// then accepts a new level only after the synchronized input has held that level
// for STABLE_CYCLES+1 consecutive sampling edges. Each accepted transition
// produces a one-cycle rise or fall pulse and increments a wrapping edge counter.
module din_debounce_sync #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din_raw,
    output logic             d_clean,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] edge_cnt,
    output logic             busy
);

    // The qualification counter only has to reach STABLE_CYCLES.
    localparam int CW = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] STAB_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = '0;

    typedef enum logic [1:0] {
        S_LOW   = 2'd0,
        S_CHK_H = 2'd1,
        S_HIGH  = 2'd2,
        S_CHK_L = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   din_s;

    state_t                 state, state_nxt;
    logic [CW-1:0]          cnt, cnt_nxt;
    logic                   d_nxt, rise_nxt, fall_nxt, accept;

    // Synchronizer chain. The FSM only ever looks at its last stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], din_raw};
    end

    assign din_s = sync_q[SYNC_STAGES-1];

    // Next-state logic: a candidate level counts up while it holds and is dropped
    // as soon as the input returns to the current clean level.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        d_nxt     = d_clean;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        accept    = 1'b0;
        case (state)
            S_LOW: begin
                d_nxt = 1'b0;
                if (din_s) begin
                    state_nxt = S_CHK_H;
                    cnt_nxt   = CNT_ONE;
                end
            end
            S_CHK_H: begin
                if (!din_s) begin
                    state_nxt = S_LOW;
                    cnt_nxt   = CNT_ZERO;
                end else if (cnt < STAB_MAX) begin
                    cnt_nxt   = cnt + CNT_ONE;
                end else begin
                    state_nxt = S_HIGH;
                    cnt_nxt   = CNT_ZERO;
                    d_nxt     = 1'b1;
                    rise_nxt  = 1'b1;
                    accept    = 1'b1;
                end
            end
            S_HIGH: begin
                d_nxt = 1'b1;
                if (!din_s) begin
                    state_nxt = S_CHK_L;
                    cnt_nxt   = CNT_ONE;
                end
            end
            S_CHK_L: begin
                if (din_s) begin
                    state_nxt = S_HIGH;
                    cnt_nxt   = CNT_ZERO;
                end else if (cnt < STAB_MAX) begin
                    cnt_nxt   = cnt + CNT_ONE;
                end else begin
                    state_nxt = S_LOW;
                    cnt_nxt   = CNT_ZERO;
                    d_nxt     = 1'b0;
                    fall_nxt  = 1'b1;
                    accept    = 1'b1;
                end
            end
            default: begin
                state_nxt = S_LOW;
                cnt_nxt   = CNT_ZERO;
                d_nxt     = 1'b0;
            end
        endcase
    end

    // State, counter and registered outputs. The edge counter wraps freely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_LOW;
            cnt      <= CNT_ZERO;
            d_clean  <= 1'b0;
            rise     <= 1'b0;
            fall     <= 1'b0;
            edge_cnt <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            d_clean  <= d_nxt;
            rise     <= rise_nxt;
            fall     <= fall_nxt;
            if (accept) edge_cnt <= edge_cnt + CNT_W'(1);
        end
    end

    // Busy is high while a candidate transition is being qualified.
    always_comb begin
        busy = (state == S_CHK_H) || (state == S_CHK_L);
    end

endmodule

// File: tb/tb_din_debounce_sync.sv
// tb_din_debounce_sync
// Drives two instances (default width and CNT_W=2) from a shared input. Every
// clock edge is compared against a run-length model: the synchronized input is
// din_raw delayed by SYNC_STAGES edges, and the clean level flips once that
// input has differed from it for STABLE_CYCLES+1 consecutive samples.
module tb_din_debounce_sync;
    localparam int SS = 2;
    localparam int SC = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       din_raw = 1'b0;
    logic       d_clean, rise, fall, busy;
    logic [7:0] edge_cnt;
    logic       d2, r2, f2, b2;
    logic [1:0] ec2;

    din_debounce_sync u_dut (
        .clk(clk), .rst_n(rst_n), .din_raw(din_raw), .d_clean(d_clean),
        .rise(rise), .fall(fall), .edge_cnt(edge_cnt), .busy(busy)
    );

    din_debounce_sync #(.CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .din_raw(din_raw), .d_clean(d2),
        .rise(r2), .fall(f2), .edge_cnt(ec2), .busy(b2)
    );

    always #5 clk = ~clk;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    obs_rise = 0;
    string phase = "init";

    // reference model state
    logic  hist[SS];
    int    run;
    logic  m_d, m_rise, m_fall;
    int    m_edges;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: got %0d expected %0d (t=%0t)", phase, tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < SS; i++) hist[i] = 1'b0;
        run = 0; m_d = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_edges = 0;
    endtask

    task automatic check_all();
        chk("d_clean",  32'(d_clean),  32'(m_d));
        chk("rise",     32'(rise),     32'(m_rise));
        chk("fall",     32'(fall),     32'(m_fall));
        chk("busy",     32'(busy),     32'(run > 0));
        chk("edge_cnt", 32'(edge_cnt), m_edges % 256);
        chk("d_clean2", 32'(d2),       32'(m_d));
        chk("rise2",    32'(r2),       32'(m_rise));
        chk("fall2",    32'(f2),       32'(m_fall));
        chk("busy2",    32'(b2),       32'(run > 0));
        chk("edge_cnt2",32'(ec2),      m_edges % 4);
    endtask

    // One clock edge with din_raw = v, then model update and full comparison.
    task automatic step(input logic v);
        logic s;
        din_raw = v;
        @(posedge clk);
        s = hist[SS-1];
        for (int i = SS - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = v;
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (s != m_d) begin
            run++;
            if (run == SC + 1) begin
                m_d = s;
                run = 0;
                m_edges++;
                if (s) m_rise = 1'b1; else m_fall = 1'b1;
            end
        end else begin
            run = 0;
        end
        #1;
        check_all();
        if (rise === 1'b1) obs_rise++;
    endtask

    // Asynchronous reset: outputs must clear with no clock edge, and stay clear
    // across an edge while reset is held. Released at a falling edge.
    task automatic do_reset(input logic v);
        din_raw = v;
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Hold din_raw at v and count edges until d_clean follows; bounded.
    task automatic lat(input logic v, input string tag);
        int  n;
        bit  seen;
        n = 0;
        seen = 0;
        while (!seen && n < 20) begin
            step(v);
            n++;
            if (d_clean === v) seen = 1;
        end
        chk(tag, 32'(n), 32'(SS + SC + 1));
    endtask

    int exp5[4] = '{1, 2, 3, 0};
    int base;

    initial begin
        model_reset();
        #1;

        phase = "t1_rise";
        do_reset(1'b0);
        repeat (2) step(1'b0);
        lat(1'b1, "latency_rise");
        chk("cnt_after_rise", 32'(edge_cnt), 32'd1);
        repeat (2) step(1'b1);

        phase = "t4_fall";
        lat(1'b0, "latency_fall");
        chk("cnt_after_fall", 32'(edge_cnt), 32'd2);
        repeat (2) step(1'b0);

        phase = "t2_glitch";
        do_reset(1'b0);
        repeat (3) step(1'b0);
        repeat (4) step(1'b1);
        repeat (10) step(1'b0);
        chk("glitch_level", 32'(d_clean), 32'd0);
        chk("glitch_cnt", 32'(edge_cnt), 32'd0);
        repeat (5) step(1'b1);
        repeat (12) step(1'b0);
        chk("pulse5_cnt", 32'(edge_cnt), 32'd2);

        phase = "t3_bounce";
        do_reset(1'b0);
        repeat (3) step(1'b0);
        base = obs_rise;
        for (int i = 0; i < 10; i++) step((i % 2) == 0);
        lat(1'b1, "settle_latency");
        repeat (3) step(1'b1);
        chk("bounce_rises", 32'(obs_rise - base), 32'd1);
        chk("bounce_cnt", 32'(edge_cnt), 32'd1);

        phase = "t5_wrap";
        do_reset(1'b0);
        repeat (3) step(1'b0);
        for (int k = 0; k < 4; k++) begin
            lat((k % 2) == 0, "wrap_latency");
            chk("wrap_cnt2", 32'(ec2), 32'(exp5[k]));
        end

        phase = "t6_midreset";
        do_reset(1'b0);
        repeat (2) step(1'b0);
        repeat (3) step(1'b1);
        chk("busy_before_reset", 32'(busy), 32'd1);
        do_reset(1'b1);
        lat(1'b1, "rise_after_reset");
        chk("cnt_after_reset", 32'(edge_cnt), 32'd1);

        phase = "random";
        do_reset(1'b0);
        for (int k = 0; k < 120; k++) begin
            logic lvl;
            int   len;
            lvl = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 9));
            if (k == 60) do_reset(1'($urandom_range(0, 1)));
            repeat (len) step(lvl);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
